// File: rtl/soc_warmboot_wb_if.sv
// Wishbone slot bundle for the warm-boot / system-control peripheral.
interface soc_warmboot_wb_if;
  logic [1:0]  addr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        we;
  logic        cyc;
  logic        ack;

  modport master (output addr, output wdata, output we, output cyc,
                  input  rdata, input ack);
  modport slave  (input  addr, input  wdata, input  we, input  cyc,
                  output rdata, output ack);
endinterface

// File: rtl/soc_warmboot_wb.sv
// Warm-boot controller: keyed delayed reboot, image select, watchdog fallback
// and boot-reason readback on a single Wishbone slot.
module soc_warmboot_wb #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DLY_W   = 16,
  parameter int unsigned WDT_W   = 16,
  parameter int unsigned PRESC_W = 10,
  parameter int unsigned WDT_IMG = 0,
  parameter logic [15:0] KEY     = 16'hB007
) (
  input  logic                 clk_24m,
  input  logic                 rst,
  soc_warmboot_wb_if.slave     wb,
  input  logic                 ext_req,
  output logic                 boot_now,
  output logic [SEL_W-1:0]     boot_sel
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  localparam logic [1:0] RSN_SW  = 2'd1;
  localparam logic [1:0] RSN_WDT = 2'd2;
  localparam logic [1:0] RSN_EXT = 2'd3;

  state_t             state, state_d;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [SEL_W-1:0]   sel, sel_d;
  logic [SEL_W-1:0]   img_d;
  logic [1:0]         reason, reason_d;
  logic [DLY_W-1:0]   dly, cnt;
  logic [WDT_W-1:0]   wdt_reload, wcnt;
  logic               wdt_en;
  logic               arm_load;
  logic [31:0]        rd_mux;

  logic access, wr, wr_csr, wr_dly, wr_wdt, wr_kick, key_ok, wdt_reload_now, wdt_expire;

  // A new access is accepted only while ack is low, giving a one-cycle ack.
  assign access         = wb.cyc & ~wb.ack;
  assign wr             = access & wb.we;
  assign wr_csr         = wr & (wb.addr == 2'd0);
  assign wr_dly         = wr & (wb.addr == 2'd1);
  assign wr_wdt         = wr & (wb.addr == 2'd2);
  assign wr_kick        = wr & (wb.addr == 2'd3);
  assign key_ok         = (wb.wdata[31:16] == KEY);
  assign wdt_reload_now = wr_wdt | wr_kick;
  assign tick           = &presc;
  // A reload in the expiry cycle cancels the expiry.
  assign wdt_expire     = wdt_en & (state != ST_FIRE) & tick & (wcnt == '0) & ~wdt_reload_now;

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= presc + PRESC_W'(1);
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Fire sources ranked wdt > ext > countdown > bus write; FIRE is terminal.
  always_comb begin
    state_d  = state;
    sel_d    = sel;
    img_d    = boot_sel;
    reason_d = reason;
    arm_load = 1'b0;
    if (state != ST_FIRE) begin
      if (wdt_expire) begin
        state_d  = ST_FIRE;
        reason_d = RSN_WDT;
        img_d    = SEL_W'(WDT_IMG);
      end else if (ext_req) begin
        state_d  = ST_FIRE;
        reason_d = RSN_EXT;
        img_d    = sel;
      end else if (state == ST_ARMED && cnt == '0) begin
        state_d  = ST_FIRE;
        reason_d = RSN_SW;
        img_d    = sel;
      end else if (wr_csr && key_ok) begin
        sel_d = wb.wdata[SEL_W-1:0];
        if (wb.wdata[8]) begin
          state_d  = ST_ARMED;
          arm_load = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      reason   <= '0;
      boot_sel <= '0;
      boot_now <= 1'b0;
    end else begin
      sel      <= sel_d;
      reason   <= reason_d;
      boot_sel <= img_d;
      boot_now <= (state_d == ST_FIRE);
    end
  end

  // Reboot countdown, saturating at zero.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      dly <= '0;
      cnt <= '0;
    end else begin
      if (wr_dly) dly <= wb.wdata[DLY_W-1:0];
      if (arm_load)                                     cnt <= dly;
      else if (state == ST_ARMED && tick && cnt != '0)  cnt <= cnt - DLY_W'(1);
    end
  end

  // Watchdog counter, saturating at zero and frozen once fired.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      wdt_en     <= 1'b0;
      wdt_reload <= '0;
      wcnt       <= '0;
    end else begin
      if (wr_wdt) begin
        wdt_en     <= wb.wdata[31];
        wdt_reload <= wb.wdata[WDT_W-1:0];
        wcnt       <= wb.wdata[WDT_W-1:0];
      end else if (wr_kick) begin
        wcnt <= wdt_reload;
      end else if (wdt_en && state != ST_FIRE && tick && wcnt != '0) begin
        wcnt <= wcnt - WDT_W'(1);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (wb.addr)
      2'd0: begin
        rd_mux[SEL_W-1:0] = sel;
        rd_mux[9:8]       = state;
        rd_mux[13:12]     = reason;
      end
      2'd1: rd_mux[DLY_W-1:0] = dly;
      2'd2: begin
        rd_mux[31]          = wdt_en;
        rd_mux[WDT_W-1:0]   = wcnt;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      wb.ack   <= 1'b0;
      wb.rdata <= '0;
    end else begin
      wb.ack   <= access;
      wb.rdata <= access ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_soc_warmboot_wb.sv
// Directed bench for soc_warmboot_wb: register table plus timed fire sequences.
module tb_soc_warmboot_wb;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned TICK  = 16;

  logic             clk_24m = 1'b0;
  logic             rst     = 1'b1;
  logic             ext_req = 1'b0;
  logic             boot_now;
  logic [SEL_W-1:0] boot_sel;
  int unsigned      edges;
  int               n_vec = 0;
  int               n_bad = 0;

  soc_warmboot_wb_if bus();

  soc_warmboot_wb #(.SEL_W(SEL_W), .PRESC_W(4), .WDT_IMG(1)) dut (
    .clk_24m (clk_24m),
    .rst     (rst),
    .wb      (bus),
    .ext_req (ext_req),
    .boot_now(boot_now),
    .boot_sel(boot_sel)
  );

  always #5 clk_24m = ~clk_24m;

  // Edges since reset release; ticks land on multiples of TICK.
  always @(posedge clk_24m or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic bn, input logic [SEL_W-1:0] bs);
    chk({name, "_out"}, 32'({boot_now, boot_sel}), 32'({bn, bs}));
  endtask

  task automatic xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd);
    int lat;
    lat = 0;
    bus.addr = a; bus.we = w; bus.wdata = d; bus.cyc = 1'b1;
    do begin
      @(posedge clk_24m); #1; lat++;
    end while (!bus.ack && lat < 8);
    rd = bus.rdata;
    chk("ack_latency", 32'(lat), 32'd1);
    bus.cyc = 1'b0; bus.we = 1'b0;
    @(posedge clk_24m); #1;
    chk("ack_single", 32'(bus.ack), 32'd0);
  endtask

  task automatic wait_edge(input int unsigned tgt, input string name);
    int guard;
    guard = 0;
    while (edges < tgt && guard < 5000) begin
      @(posedge clk_24m); #1; guard++;
    end
    chk({name, "_sync"}, edges, tgt);
  endtask

  function automatic int unsigned next_base();
    return ((edges / TICK) + 1) * TICK;
  endfunction

  task automatic do_reset();
    bus.cyc = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; ext_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_24m);
    @(negedge clk_24m) rst = 1'b0;
    #1;
  endtask

  logic [31:0] rd;
  int unsigned base;

  initial begin
    vecs[0]  = '{2'd0, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[1]  = '{2'd0, 1'b1, 32'h1234_0101, 1'b0, 32'h0};
    vecs[2]  = '{2'd0, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{2'd0, 1'b1, 32'hB007_0003, 1'b0, 32'h0};
    vecs[4]  = '{2'd0, 1'b0, 32'h0,         1'b1, 32'h3};
    vecs[5]  = '{2'd1, 1'b1, 32'h1234_0003, 1'b0, 32'h0};
    vecs[6]  = '{2'd1, 1'b0, 32'h0,         1'b1, 32'h3};
    vecs[7]  = '{2'd3, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{2'd2, 1'b1, 32'h0000_0009, 1'b0, 32'h0};
    vecs[9]  = '{2'd2, 1'b0, 32'h0,         1'b1, 32'h9};
    vecs[10] = '{2'd0, 1'b1, 32'hB007_0002, 1'b0, 32'h0};
    vecs[11] = '{2'd0, 1'b0, 32'h0,         1'b1, 32'h2};

    do_reset();
    chk_out("reset", 1'b0, 2'd0);
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);

    // Register-level table: keys, readback, no fire
    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].addr, vecs[i].we, vecs[i].wdata, rd);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk_out($sformatf("vec%0d", i), 1'b0, 2'd0);
    end

    // Software countdown DLY=3
    do_reset();
    xfer(2'd1, 1'b1, 32'd3, rd);
    base = next_base();
    wait_edge(base, "sw");
    xfer(2'd0, 1'b1, 32'hB007_0102, rd);
    xfer(2'd0, 1'b0, 32'h0, rd);
    chk("sw_armed_csr", rd, 32'h0000_0102);
    wait_edge(base + 48, "sw_pre");
    chk_out("sw_pre", 1'b0, 2'd0);
    wait_edge(base + 49, "sw_fire");
    chk_out("sw_fire", 1'b1, 2'd2);
    xfer(2'd0, 1'b0, 32'h0, rd);
    chk("sw_csr", rd, 32'h0000_1202);

    // DLY=0 fires the cycle after arming
    do_reset();
    bus.addr = 2'd0; bus.we = 1'b1; bus.wdata = 32'hB007_0101; bus.cyc = 1'b1;
    @(posedge clk_24m); #1;
    chk("dly0_ack", 32'(bus.ack), 32'd1);
    chk_out("dly0_armed", 1'b0, 2'd0);
    bus.cyc = 1'b0; bus.we = 1'b0;
    @(posedge clk_24m); #1;
    chk_out("dly0_fire", 1'b1, 2'd1);

    // Watchdog expiry into fallback image
    do_reset();
    xfer(2'd0, 1'b1, 32'hB007_0003, rd);
    base = next_base();
    wait_edge(base, "wdt");
    xfer(2'd2, 1'b1, 32'h8000_0005, rd);
    wait_edge(base + 95, "wdt_pre");
    chk_out("wdt_pre", 1'b0, 2'd0);
    wait_edge(base + 96, "wdt_fire");
    chk_out("wdt_fire", 1'b1, 2'd1);
    xfer(2'd0, 1'b0, 32'h0, rd);
    chk("wdt_csr", rd, 32'h0000_2203);
    xfer(2'd2, 1'b0, 32'h0, rd);
    chk("wdt_reg", rd, 32'h8000_0000);

    // Kick every 3 ticks for about 100 ticks
    do_reset();
    base = next_base();
    wait_edge(base, "kick");
    xfer(2'd2, 1'b1, 32'h8000_0005, rd);
    for (int k = 1; k <= 33; k++) begin
      wait_edge(base + 48 * k, "kick_k");
      xfer(2'd3, 1'b1, 32'h0, rd);
    end
    chk_out("kick_nofire", 1'b0, 2'd0);
    xfer(2'd0, 1'b0, 32'h0, rd);
    chk("kick_csr", rd, 32'h0);

    // Kick lands exactly in the expiry cycle
    do_reset();
    base = next_base();
    wait_edge(base, "kexp");
    xfer(2'd2, 1'b1, 32'h8000_0005, rd);
    wait_edge(base + 95, "kexp_pre");
    xfer(2'd3, 1'b1, 32'h0, rd);
    chk_out("kexp_nofire", 1'b0, 2'd0);
    xfer(2'd2, 1'b0, 32'h0, rd);
    chk("kexp_wcnt", rd, 32'h8000_0005);

    // External request while armed
    do_reset();
    xfer(2'd1, 1'b1, 32'd10, rd);
    base = next_base();
    wait_edge(base, "ext");
    xfer(2'd0, 1'b1, 32'hB007_0103, rd);
    wait_edge(base + 69, "ext_pre");
    chk_out("ext_pre", 1'b0, 2'd0);
    ext_req = 1'b1;
    @(posedge clk_24m); #1;
    ext_req = 1'b0;
    chk_out("ext_fire", 1'b1, 2'd3);
    xfer(2'd0, 1'b0, 32'h0, rd);
    chk("ext_csr", rd, 32'h0000_3203);
    xfer(2'd0, 1'b1, 32'hB007_0002, rd);
    xfer(2'd0, 1'b0, 32'h0, rd);
    chk("ext_locked_csr", rd, 32'h0000_3203);
    chk_out("ext_locked", 1'b1, 2'd3);

    // Reset mid-countdown
    do_reset();
    xfer(2'd1, 1'b1, 32'd50, rd);
    base = next_base();
    wait_edge(base, "rst");
    xfer(2'd0, 1'b1, 32'hB007_0102, rd);
    wait_edge(base + 320 + 3, "rst_mid");
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 2'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    repeat (3) @(posedge clk_24m);
    @(negedge clk_24m) rst = 1'b0;
    repeat (60 * TICK) @(posedge clk_24m);
    #1;
    chk_out("rst_nofire", 1'b0, 2'd0);
    xfer(2'd0, 1'b0, 32'h0, rd);
    chk("rst_csr", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
